// File: rtl/jk_excitation_seq.sv
// -----------------------------------------------------------------------------
// jk_excitation_seq
//
// Purpose:
//   Moves a bank of external JK flip-flop cells to a requested value. The
//   value is loaded directly or reached by counting up or down one step at a
//   time. Every step is one DRIVE cycle with J/K excitation, one SETTLE cycle
//   (master-slave cells update on the falling edge), and one CHECK cycle. In
//   CHECK the sensed cell outputs are compared with the expected value.
//
// Ports:
//   clk        single clock, all state changes on posedge
//   rst_n      asynchronous active-low reset
//   tgt_valid  request valid
//   tgt_ready  idle, able to accept a request (state == IDLE)
//   tgt_data   requested final cell value
//   mode       00 load direct, 01 count up, 10 count down, 11 reserved
//   fb_q       q outputs of the external cells
//   j, k       registered per-cell excitation, zero outside DRIVE
//   busy       state != IDLE
//   done       one-cycle completion pulse
//   err        sticky error, cleared by the next accepted request
// -----------------------------------------------------------------------------
module jk_excitation_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] fb_q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_CHECK  = 2'd3;

    localparam logic [1:0] M_LOAD = 2'b00;
    localparam logic [1:0] M_UP   = 2'b01;
    localparam logic [1:0] M_DOWN = 2'b10;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_tgt;
    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic             r_done;
    logic             r_err;

    logic [1:0]       w_state_next;
    logic [1:0]       w_mode_next;
    logic [WIDTH-1:0] w_tgt_next;
    logic [WIDTH-1:0] w_cur_next;
    logic [WIDTH-1:0] w_exp_next;
    logic             w_done_next;
    logic             w_err_next;
    logic             w_enter_drive;
    logic [WIDTH-1:0] w_j_exc;
    logic [WIDTH-1:0] w_k_exc;

    always_comb begin
        w_state_next  = r_state;
        w_mode_next   = r_mode;
        w_tgt_next    = r_tgt;
        w_cur_next    = r_cur;
        w_exp_next    = r_exp;
        w_done_next   = 1'b0;
        w_err_next    = r_err;
        w_enter_drive = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (tgt_valid) begin
                    w_tgt_next  = tgt_data;
                    w_mode_next = mode;
                    w_cur_next  = fb_q;
                    w_err_next  = 1'b0;
                    case (mode)
                        M_LOAD: begin
                            // A load always makes one pass, even when the
                            // cells already hold the target.
                            w_exp_next    = tgt_data;
                            w_state_next  = S_DRIVE;
                            w_enter_drive = 1'b1;
                        end
                        M_UP, M_DOWN: begin
                            w_exp_next = (mode == M_UP) ? fb_q + ONE : fb_q - ONE;
                            if (fb_q == tgt_data) begin
                                // Already there: finish without driving.
                                w_done_next = 1'b1;
                            end else begin
                                w_state_next  = S_DRIVE;
                                w_enter_drive = 1'b1;
                            end
                        end
                        default: begin
                            w_err_next = 1'b1;
                        end
                    endcase
                end
            end
            S_DRIVE:  w_state_next = S_SETTLE;
            S_SETTLE: w_state_next = S_CHECK;
            default: begin
                if (fb_q != r_exp) begin
                    w_err_next   = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_exp == r_tgt) begin
                    w_done_next  = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    // Only count modes reach here; load always has exp == tgt.
                    w_cur_next    = r_exp;
                    w_exp_next    = (r_mode == M_UP) ? r_exp + ONE : r_exp - ONE;
                    w_state_next  = S_DRIVE;
                    w_enter_drive = 1'b1;
                end
            end
        endcase
    end

    // Excitation toward the next expected value: set bits that must rise,
    // reset bits that must fall, hold the rest. J and K are never both set.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_exc
            assign w_j_exc[gi] = ~w_cur_next[gi] &  w_exp_next[gi];
            assign w_k_exc[gi] =  w_cur_next[gi] & ~w_exp_next[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= M_LOAD;
            r_tgt   <= '0;
            r_cur   <= '0;
            r_exp   <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_mode  <= w_mode_next;
            r_tgt   <= w_tgt_next;
            r_cur   <= w_cur_next;
            r_exp   <= w_exp_next;
            r_j     <= w_enter_drive ? w_j_exc : '0;
            r_k     <= w_enter_drive ? w_k_exc : '0;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
        end
    end

    assign tgt_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign j         = r_j;
    assign k         = r_k;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_jk_excitation_seq.sv
// -----------------------------------------------------------------------------
// tb_jk_excitation_seq
//
// Drives jk_excitation_seq with directed and random requests against a bank of
// modelled JK cells (falling-edge update, optional stuck-at bits). Expected
// outcome, latency and drive count come from a step-list reference model.
// -----------------------------------------------------------------------------
module tb_jk_excitation_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tgt_valid;
    logic         tgt_ready;
    logic [W-1:0] tgt_data;
    logic [1:0]   mode;
    logic [W-1:0] fb_q;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         busy;
    logic         done;
    logic         err;

    // external cell model
    logic [W-1:0] cell_q    = '0;
    logic [W-1:0] load_val  = '0;
    logic         load_cell = 1'b0;
    logic [W-1:0] stuck_m   = '0;
    logic [W-1:0] stuck_v   = '0;
    int           drive_cnt = 0;
    int           toggle_cnt = 0;

    int checks = 0;
    int errors = 0;

    jk_excitation_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_data  (tgt_data),
        .mode      (mode),
        .fb_q      (fb_q),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    assign fb_q = (cell_q & ~stuck_m) | (stuck_v & stuck_m);

    always @(negedge clk) begin
        if (load_cell) begin
            cell_q <= load_val;
        end else begin
            if ((j & k) != '0) toggle_cnt <= toggle_cnt + 1;
            if ((j | k) != '0) drive_cnt  <= drive_cnt + 1;
            cell_q <= (j & ~cell_q) | (~k & cell_q);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic run_txn(input int id, input logic [W-1:0] start, input logic [1:0] md,
                           input logic [W-1:0] tgt, input logic [W-1:0] sm,
                           input logic [W-1:0] sv, input bit poke_busy, input bit rel_rst);
        logic [W-1:0] cur, v, nxt, fe, fbv;
        bit  e_done, e_err;
        int  lat, drv, n, cyc, d0, t0;

        stuck_m   = sm;
        stuck_v   = sv;
        load_val  = start;
        load_cell = 1'b1;
        @(negedge clk);
        #1;
        load_cell = 1'b0;

        // reference: list of expected values, one per step
        cur = (start & ~sm) | (sv & sm);
        e_done = 0; e_err = 0; lat = 0; drv = 0; fe = '0;
        if (md == 2'b11) begin
            e_err = 1;
        end else if (md != 2'b00 && cur == tgt) begin
            e_done = 1;
        end else begin
            v = cur;
            for (n = 1; n <= 16; n++) begin
                nxt = (md == 2'b00) ? tgt : (md == 2'b01) ? 4'(v + 1) : 4'(v - 1);
                if (n == 1) fe = nxt;
                if (nxt != v) drv++;
                fbv = (nxt & ~sm) | (sv & sm);
                if (fbv != nxt) begin e_err = 1; lat = 3 * n; break; end
                if (nxt == tgt) begin e_done = 1; lat = 3 * n; break; end
                v = nxt;
            end
        end

        d0 = drive_cnt;
        t0 = toggle_cnt;
        tgt_data  = tgt;
        mode      = md;
        tgt_valid = 1'b1;
        if (rel_rst) rst_n = 1'b1;
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;

        check("busy_after_accept", busy, (lat > 0));
        check("j_first", j, (lat > 0) ? (fe & ~cur) : '0);
        check("k_first", k, (lat > 0) ? (cur & ~fe) : '0);
        if (md != 2'b11) check("err_cleared", err, 0);

        cyc = 0;
        while (!(done || err) && cyc < 100) begin
            if (poke_busy && cyc == 1) begin
                tgt_valid = 1'b1;
                tgt_data  = $urandom_range(0, 15);
                mode      = 2'b00;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (poke_busy && cyc == 3) tgt_valid = 1'b0;
        end
        check("latency", cyc, lat);
        check("done", done, e_done);
        check("err", err, e_err);
        check("ready_at_end", tgt_ready, 1);
        check("busy_at_end", busy, 0);
        check("drive_cycles", drive_cnt - d0, drv);
        check("no_toggle", toggle_cnt - t0, 0);

        @(posedge clk);
        #1;
        check("done_pulse", done, 0);
        check("err_sticky", err, e_err);
        check("jk_idle", {j, k}, '0);

        $display("txn %0d: start=%b mode=%b tgt=%b stuck=%b/%b -> done=%0d err=%0d cycles=%0d",
                 id, start, md, tgt, sm, sv, e_done, e_err, lat);
    endtask

    initial begin
        logic [W-1:0] rs, rt, rm;
        logic [1:0]   rmd;
        int           r;

        rst_n     = 1'b0;
        tgt_valid = 1'b0;
        tgt_data  = '0;
        mode      = 2'b00;
        #1;
        check("rst_j", j, 0);
        check("rst_k", k, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", tgt_ready, 1);
        @(negedge clk);

        // load, first accept right after reset release
        run_txn(0, 4'b0101, 2'b00, 4'b1010, 4'b0000, 4'b0000, 0, 1);
        // count up 3 steps
        run_txn(1, 4'b0011, 2'b01, 4'b0110, 4'b0000, 4'b0000, 0, 0);
        // count down across wrap
        run_txn(2, 4'b0001, 2'b10, 4'b1110, 4'b0000, 4'b0000, 0, 0);
        // bit 2 stuck at 0 on load of 1111
        run_txn(3, 4'b0000, 2'b00, 4'b1111, 4'b0100, 4'b0000, 0, 0);
        // next accept clears err
        run_txn(4, 4'b1001, 2'b00, 4'b0110, 4'b0000, 4'b0000, 0, 0);
        // count with cells already at target
        run_txn(5, 4'b0111, 2'b01, 4'b0111, 4'b0000, 4'b0000, 0, 0);
        // load with cells already at target still makes one pass
        run_txn(6, 4'b1100, 2'b00, 4'b1100, 4'b0000, 4'b0000, 0, 0);
        // reserved mode
        run_txn(7, 4'b0010, 2'b11, 4'b1000, 4'b0000, 4'b0000, 0, 0);
        // request while busy is ignored
        run_txn(8, 4'b1110, 2'b01, 4'b0011, 4'b0000, 4'b0000, 1, 0);

        // reset during SETTLE of a count
        load_val  = 4'b0000;
        load_cell = 1'b1;
        @(negedge clk);
        #1;
        load_cell = 1'b0;
        tgt_data  = 4'b1000;
        mode      = 2'b01;
        tgt_valid = 1'b1;
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_j", j, 0);
        check("rst_mid_k", k, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", tgt_ready, 1);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_mid_done", done, 0);
        end
        run_txn(9, 4'b0100, 2'b10, 4'b0001, 4'b0000, 4'b0000, 0, 1);

        for (int i = 10; i < 50; i++) begin
            rs = $urandom_range(0, 15);
            rt = $urandom_range(0, 15);
            r  = $urandom_range(0, 9);
            rmd = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            if (rmd != 2'b00 && $urandom_range(0, 9) == 0) rt = rs;
            rm = '0;
            if ($urandom_range(0, 4) == 0) rm = 4'(1 << $urandom_range(0, 3));
            run_txn(i, rs, rmd, rt, rm, 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) == 0), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_excitation_seq.md
JK_EXCITATION_SEQ -- requirements
Module: jk_excitation_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the number of external JK flip-flop cells driven and sensed.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port tgt_valid, input, 1, target request valid.
REQ-005 The block SHALL have port tgt_ready, output, 1, block idle and able to accept a request.
REQ-006 The block SHALL have port tgt_data, input, WIDTH, requested final cell value.
REQ-007 The block SHALL have port mode, input, 2, with 00 = load direct, 01 = count up to target, 10 = count down to target, 11 = reserved.
REQ-008 The block SHALL have port fb_q, input, WIDTH, the q outputs of the external JK cells.
REQ-009 The block SHALL have ports j and k, output, WIDTH each, per-cell excitation.
REQ-010 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-011 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-012 The block SHALL have port err, output, 1, sticky error flag.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE, SETTLE and CHECK.
REQ-014 A request SHALL be accepted on a posedge where tgt_valid && tgt_ready.
  - tgt_data and mode are registered at that edge.
  - fb_q is registered at that edge as cur.
  - err is cleared at that edge.
REQ-015 tgt_ready SHALL equal (state == IDLE); a request presented while busy SHALL be ignored, not queued.
REQ-016 The first expected value exp at accept SHALL be:
  - mode 00: tgt_data.
  - mode 01: cur+1 mod 2^WIDTH.
  - mode 10: cur-1 mod 2^WIDTH.
REQ-017 When mode is 01 or 10 and cur == tgt_data at accept, the block SHALL return to IDLE with no drive and pulse done in the next cycle.
REQ-018 When mode is 00 and cur == tgt_data at accept, the block SHALL still perform one DRIVE/SETTLE/CHECK pass.
REQ-019 When mode == 11 at accept, the block SHALL stay in IDLE, set err, and not pulse done.
REQ-020 j and k SHALL be registered outputs, with j = k = 0 in every state except DRIVE.
REQ-021 In DRIVE, per bit i, from cur[i] -> exp[i], the outputs SHALL be:
  - 0->0: J=0, K=0.
  - 0->1: J=1, K=0.
  - 1->0: J=0, K=1.
  - 1->1: J=0, K=0.
  - Toggle (J=K=1) SHALL never be driven.
REQ-022 DRIVE SHALL last exactly 1 cycle, then SETTLE for exactly 1 cycle (this lets master-slave cells update on the falling edge), then CHECK for exactly 1 cycle.
REQ-023 In CHECK, fb_q SHALL be compared to exp, with the following outcomes:
  - Mismatch: set err, go to IDLE, no done.
  - Match and exp == tgt: go to IDLE and pulse done in the following cycle.
  - Match and exp != tgt: set cur = exp, set exp = exp±1 (wrap modulo 2^WIDTH), go to DRIVE.
REQ-024 Load latency SHALL be: with accept at edge E0, j/k valid in cycle E0..E1, and done high in cycle E3..E4 with tgt_ready high in the same cycle.
REQ-025 A count of N steps SHALL take 3N cycles from accept to the done edge.
REQ-026 Count modes SHALL wrap: up from 2^WIDTH-1 goes to 0, and down from 0 goes to 2^WIDTH-1.
REQ-027 err SHALL remain high until the next accepted request or reset; done and err SHALL never be high in the same cycle.
REQ-028 fb_q changing outside CHECK SHALL have no effect.

Reset
REQ-029 While rst_n = 0, the block SHALL asynchronously force:
  - state = IDLE.
  - j = k = 0.
  - done = 0, err = 0, busy = 0, tgt_ready = 1.
  - cur = 0, exp = 0.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first accept SHALL be possible on the first posedge after rst_n rises.

Verification
REQ-031 Scenario, load: WIDTH=4, fb_q=0101, mode 00, tgt 1010 -> j=1010, k=0101 for 1 cycle; model cells update; done pulses 3 cycles after accept; err=0.
REQ-032 Scenario, count up: fb_q=0011, mode 01, tgt 0110 -> exactly 3 DRIVE cycles (excitations toward 0100, 0101, 0110); done 9 cycles after accept.
REQ-033 Scenario, wrap: fb_q=0001, mode 10, tgt 1110 -> sequence 0000, 1111, 1110; done after 9 cycles; no J=K=1 ever driven.
REQ-034 Scenario, error: mode 00, tgt 1111, model cell bit 2 stuck at 0 -> err=1 in the cycle after CHECK, no done, tgt_ready=1; next accept clears err.
REQ-035 Scenario, boundary: mode 01 with fb_q = tgt = 0111 -> no DRIVE, done next cycle; mode 11 -> err=1, no drive; tgt_valid while busy -> ignored.
REQ-036 Scenario, reset: rst_n low during SETTLE of a count -> j=k=0, busy=0 immediately, no done; a new accept succeeds on the first edge after release.
